// File: rtl/boom_ras_pkg.sv
// rtl/boom_ras_pkg.sv - return-address-stack sizing, index/count types and checkpoint record
package boom_ras_pkg;

  localparam int NRAS    = 32;
  localparam int IDX_W   = 5;
  localparam int VADDR_W = 40;

  typedef logic [IDX_W-1:0] ras_idx_t;
  typedef logic [IDX_W:0]   ras_cnt_t;

  typedef struct packed {
    ras_idx_t ptr;
    ras_cnt_t count;
  } ras_ckpt_t;

  localparam ras_cnt_t RAS_CNT_MAX = ras_cnt_t'(NRAS);

endpackage

// File: rtl/boom_ras_ctrl.sv
// rtl/boom_ras_ctrl.sv - RAS pointer/occupancy controller; BOOM_RAS_CTRL_PERF_EN adds perf counters
module boom_ras_ctrl
  import boom_ras_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               io_push,
  input  logic [VADDR_W-1:0] io_push_addr,
  input  logic               io_pop,
  input  logic               io_repair_valid,
  input  logic [IDX_W-1:0]   io_repair_ptr,
  input  logic [IDX_W:0]     io_repair_count,
  input  logic               io_repair_wr,
  input  logic [VADDR_W-1:0] io_repair_addr,
  output logic [IDX_W-1:0]   io_ckpt_ptr,
  output logic [IDX_W:0]     io_ckpt_count,
  output logic [IDX_W-1:0]   io_ras_read_idx,
  output logic               io_ras_write_valid,
  output logic [IDX_W-1:0]   io_ras_write_idx,
  output logic [VADDR_W-1:0] io_ras_write_addr,
`ifdef BOOM_RAS_CTRL_PERF_EN
  output logic [31:0]        io_perf_overflow,
  output logic [31:0]        io_perf_underflow,
  output logic [31:0]        io_perf_repair,
`endif
  input  logic [VADDR_W-1:0] io_ras_read_addr,
  output logic               io_pred_valid,
  output logic [VADDR_W-1:0] io_pred_target
);

  ras_ckpt_t st_q, st_d;
  logic      pred_valid_q;

  always_comb begin
    st_d               = st_q;
    io_ras_write_valid = 1'b0;
    io_ras_write_idx   = st_q.ptr;
    io_ras_write_addr  = io_push_addr;
    if (reset) begin
      st_d.ptr   = '0;
      st_d.count = '0;
    end else if (io_repair_valid) begin
      st_d.ptr   = io_repair_ptr;
      st_d.count = (io_repair_count > RAS_CNT_MAX) ? RAS_CNT_MAX : io_repair_count;
      if (io_repair_wr) begin
        io_ras_write_valid = 1'b1;
        io_ras_write_idx   = io_repair_ptr;
        io_ras_write_addr  = io_repair_addr;
      end
    end else if (io_push && io_pop) begin
      // replace-top: overwrite current entry, pointer and occupancy untouched
      io_ras_write_valid = 1'b1;
    end else if (io_push) begin
      io_ras_write_valid = 1'b1;
      io_ras_write_idx   = st_q.ptr + 1'b1;
      st_d.ptr           = st_q.ptr + 1'b1;
      st_d.count         = (st_q.count == RAS_CNT_MAX) ? st_q.count : st_q.count + 1'b1;
    end else if (io_pop) begin
      st_d.ptr   = st_q.ptr - 1'b1;
      st_d.count = (st_q.count == '0) ? st_q.count : st_q.count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q         <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      pred_valid_q <= (st_d.count != '0);
    end
  end

  assign io_ras_read_idx = st_d.ptr;
  assign io_ckpt_ptr     = st_q.ptr;
  assign io_ckpt_count   = st_q.count;
  assign io_pred_valid   = pred_valid_q;
  assign io_pred_target  = io_ras_read_addr;

`ifdef BOOM_RAS_CTRL_PERF_EN
  logic        ev_overflow, ev_underflow;
  logic [31:0] perf_ovf_q, perf_unf_q, perf_rep_q;

  assign ev_overflow  = io_push && !io_pop && !io_repair_valid && (st_q.count == RAS_CNT_MAX);
  assign ev_underflow = io_pop && !io_push && !io_repair_valid && (st_q.count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ovf_q <= '0;
      perf_unf_q <= '0;
      perf_rep_q <= '0;
    end else begin
      if (ev_overflow && perf_ovf_q != '1)     perf_ovf_q <= perf_ovf_q + 32'd1;
      if (ev_underflow && perf_unf_q != '1)    perf_unf_q <= perf_unf_q + 32'd1;
      if (io_repair_valid && perf_rep_q != '1) perf_rep_q <= perf_rep_q + 32'd1;
    end
  end

  assign io_perf_overflow  = perf_ovf_q;
  assign io_perf_underflow = perf_unf_q;
  assign io_perf_repair    = perf_rep_q;
`else
  // perf counters compiled out
`endif

endmodule

// File: tb/tb_boom_ras_ctrl.sv
// tb/tb_boom_ras_ctrl.sv - directed table, overflow sequence and randomized model check of boom_ras_ctrl
module tb_boom_ras_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_push, io_pop, io_repair_valid, io_repair_wr;
  logic [39:0] io_push_addr, io_repair_addr;
  logic [4:0]  io_repair_ptr;
  logic [5:0]  io_repair_count;
  logic [4:0]  io_ckpt_ptr, io_ras_read_idx, io_ras_write_idx;
  logic [5:0]  io_ckpt_count;
  logic        io_ras_write_valid, io_pred_valid;
  logic [39:0] io_ras_write_addr, io_ras_read_addr, io_pred_target;
`ifdef BOOM_RAS_CTRL_PERF_EN
  logic [31:0] io_perf_overflow, io_perf_underflow, io_perf_repair;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  boom_ras_ctrl dut (
    .clock(clock), .reset(reset),
    .io_push(io_push), .io_push_addr(io_push_addr), .io_pop(io_pop),
    .io_repair_valid(io_repair_valid), .io_repair_ptr(io_repair_ptr),
    .io_repair_count(io_repair_count), .io_repair_wr(io_repair_wr),
    .io_repair_addr(io_repair_addr),
    .io_ckpt_ptr(io_ckpt_ptr), .io_ckpt_count(io_ckpt_count),
    .io_ras_read_idx(io_ras_read_idx), .io_ras_write_valid(io_ras_write_valid),
    .io_ras_write_idx(io_ras_write_idx), .io_ras_write_addr(io_ras_write_addr),
`ifdef BOOM_RAS_CTRL_PERF_EN
    .io_perf_overflow(io_perf_overflow), .io_perf_underflow(io_perf_underflow),
    .io_perf_repair(io_perf_repair),
`endif
    .io_ras_read_addr(io_ras_read_addr),
    .io_pred_valid(io_pred_valid), .io_pred_target(io_pred_target)
  );

  // storage array beside the controller: 1-cycle read, write bypass
  logic [39:0] mem [32];
  logic [39:0] rd_q;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rd_q = '0;
  end
  always @(posedge clock) begin
    if (io_ras_write_valid) mem[io_ras_write_idx] <= io_ras_write_addr;
    rd_q <= (io_ras_write_valid && io_ras_write_idx == io_ras_read_idx) ? io_ras_write_addr
                                                                          : mem[io_ras_read_idx];
  end
  assign io_ras_read_addr = rd_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic push, input logic pop, input logic rv,
                       input logic [4:0] rp, input logic [5:0] rc, input logic rw,
                       input logic [39:0] pa, input logic [39:0] ra);
    reset = rst; io_push = push; io_pop = pop; io_repair_valid = rv;
    io_repair_ptr = rp; io_repair_count = rc; io_repair_wr = rw;
    io_push_addr = pa; io_repair_addr = ra;
  endtask

  typedef struct {
    logic        rst, push, pop, rv, rw;
    logic [4:0]  rp;
    logic [5:0]  rc;
    logic [39:0] pa, ra;
    logic        e_wv;
    logic [4:0]  e_widx, e_ridx, e_cptr;
    logic [39:0] e_waddr;
    logic [5:0]  e_ccnt;
    logic        e_pv, chk_tgt;
    logic [39:0] e_tgt;
  } vec_t;

  localparam logic [39:0] A = 40'h00_0000_1000, B = 40'h00_0000_2000, C = 40'h00_0000_3000;
  localparam logic [39:0] X = 40'h00_00AA_0000, Y = 40'h00_00BB_0000, Z = 40'h00_00CC_0000;
  localparam logic [39:0] PB = 40'h00_0005_0000;

  vec_t vt [$];

  function automatic vec_t mk(logic rst, logic push, logic pop, logic rv, logic [4:0] rp,
                              logic [5:0] rc, logic rw, logic [39:0] pa, logic [39:0] ra,
                              logic wv, logic [4:0] widx, logic [39:0] waddr, logic [4:0] ridx,
                              logic [4:0] cptr, logic [5:0] ccnt, logic pv, logic ct,
                              logic [39:0] tgt);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop; v.rv = rv; v.rp = rp; v.rc = rc; v.rw = rw;
    v.pa = pa; v.ra = ra; v.e_wv = wv; v.e_widx = widx; v.e_waddr = waddr; v.e_ridx = ridx;
    v.e_cptr = cptr; v.e_ccnt = ccnt; v.e_pv = pv; v.chk_tgt = ct; v.e_tgt = tgt;
    return v;
  endfunction

  // higher-level reference: stack contents plus pointer/occupancy as plain ints
  logic [39:0] stk [32];
  int          m_ptr, m_cnt;
  logic        m_pv_prev;
  logic [39:0] m_tgt_prev;

  initial begin
    vec_t v;
    int   rst_i, push_i, pop_i, rv_i, rw_i, rp_i, rc_i;
    logic [39:0] pa_r, ra_r;
    int   e_wv, e_widx, e_ridx;
    logic [39:0] e_waddr;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);

    // rows: inputs ... | wv widx waddr ridx cptr ccnt pv chk_tgt tgt
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0, 0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,A,0, 1,1,A, 1, 0,0, 0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,B,0, 1,2,B, 2, 1,1, 1,1,A));
    vt.push_back(mk(0,1,0,0,0,0,0,C,0, 1,3,C, 3, 2,2, 1,1,B));
    vt.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0, 2, 3,3, 1,1,C));
    vt.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0, 1, 2,2, 1,1,B));
    vt.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0, 0, 1,1, 1,1,A));
    vt.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0, 31, 0,0, 0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 31, 31,0, 0,0,0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,0,0,0,0,0,PB+40'(i),0, 1,5'(i),PB+40'(i), 5'(i),
                      5'(i+31), 6'(i), (i != 0), (i != 0), PB+40'(i-1)));
    vt.push_back(mk(0,1,1,0,0,0,0,X,0, 1,4,X, 4, 4,5, 1,1,PB+40'd4));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 4, 4,5, 1,1,X));
    vt.push_back(mk(0,1,0,1,7,5,1,Z,Y, 1,7,Y, 7, 4,5, 1,1,X));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 7, 7,5, 1,1,Y));
    vt.push_back(mk(0,0,1,1,9,40,0,0,0, 0,0,0, 9, 7,5, 1,1,Y));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 9, 9,32, 1,0,0));
    vt.push_back(mk(1,1,0,0,0,0,0,Z,0, 0,0,0, 0, 9,32, 1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0, 0,0,0));

    foreach (vt[k]) begin
      v = vt[k];
      @(posedge clock); #1;
      drive(v.rst, v.push, v.pop, v.rv, v.rp, v.rc, v.rw, v.pa, v.ra);
      @(negedge clock);
      chk($sformatf("row%0d write_valid", k), 64'(io_ras_write_valid), 64'(v.e_wv));
      if (v.e_wv) begin
        chk($sformatf("row%0d write_idx", k), 64'(io_ras_write_idx), 64'(v.e_widx));
        chk($sformatf("row%0d write_addr", k), 64'(io_ras_write_addr), 64'(v.e_waddr));
      end
      chk($sformatf("row%0d read_idx", k), 64'(io_ras_read_idx), 64'(v.e_ridx));
      chk($sformatf("row%0d ckpt_ptr", k), 64'(io_ckpt_ptr), 64'(v.e_cptr));
      chk($sformatf("row%0d ckpt_count", k), 64'(io_ckpt_count), 64'(v.e_ccnt));
      chk($sformatf("row%0d pred_valid", k), 64'(io_pred_valid), 64'(v.e_pv));
      if (v.chk_tgt) chk($sformatf("row%0d pred_target", k), 64'(io_pred_target), 64'(v.e_tgt));
    end

    // 33 pushes from reset: occupancy saturates, 33rd push wraps to idx 1
    @(posedge clock); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) begin
      @(posedge clock); #1;
      drive(0, 1, 0, 0, 0, 0, 0, 40'h77_0000_0000 + 40'(i), 0);
      @(negedge clock);
      if (i == 32 || i == 0 || i == 31)
        chk($sformatf("ovf push%0d write_idx", i), 64'(io_ras_write_idx), 64'((i + 1) % 32));
    end
    @(posedge clock); #1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("ovf count_sat", 64'(io_ckpt_count), 64'd32);
    chk("ovf ptr", 64'(io_ckpt_ptr), 64'd1);
    chk("ovf target", 64'(io_pred_target), 64'h77_0000_0020);
`ifdef BOOM_RAS_CTRL_PERF_EN
    chk("perf_overflow", 64'(io_perf_overflow), 64'd1);
`endif

    // randomized traffic against the stack model
    @(posedge clock); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    m_ptr = 0; m_cnt = 0; m_pv_prev = 0; m_tgt_prev = '0;
    for (int i = 0; i < 32; i++) stk[i] = mem[i];
    for (int n = 0; n < 3000; n++) begin
      rst_i  = ($urandom_range(0, 99) == 0);
      rv_i   = ($urandom_range(0, 15) == 0);
      push_i = $urandom_range(0, 1);
      pop_i  = $urandom_range(0, 1);
      rw_i   = $urandom_range(0, 1);
      rp_i   = $urandom_range(0, 31);
      rc_i   = $urandom_range(0, 63);
      pa_r   = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
      ra_r   = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
      @(posedge clock); #1;
      drive(rst_i[0], push_i[0], pop_i[0], rv_i[0], 5'(rp_i), 6'(rc_i), rw_i[0], pa_r, ra_r);
      @(negedge clock);
      chk("rnd ckpt_ptr", 64'(io_ckpt_ptr), 64'(m_ptr));
      chk("rnd ckpt_count", 64'(io_ckpt_count), 64'(m_cnt));
      chk("rnd pred_valid", 64'(io_pred_valid), 64'(m_pv_prev));
      if (m_pv_prev) chk("rnd pred_target", 64'(io_pred_target), 64'(m_tgt_prev));
      e_wv = 0; e_widx = 0; e_waddr = pa_r;
      if (rst_i != 0) begin
        m_ptr = 0; m_cnt = 0;
      end else if (rv_i != 0) begin
        m_ptr = rp_i; m_cnt = (rc_i > 32) ? 32 : rc_i;
        if (rw_i != 0) begin e_wv = 1; e_widx = rp_i; e_waddr = ra_r; end
      end else if (push_i != 0 && pop_i != 0) begin
        e_wv = 1; e_widx = m_ptr;
      end else if (push_i != 0) begin
        m_ptr = (m_ptr + 1) % 32; m_cnt = (m_cnt < 32) ? m_cnt + 1 : 32;
        e_wv = 1; e_widx = m_ptr;
      end else if (pop_i != 0) begin
        m_ptr = (m_ptr + 31) % 32; m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      end
      e_ridx = m_ptr;
      chk("rnd write_valid", 64'(io_ras_write_valid), 64'(e_wv));
      if (e_wv != 0) begin
        chk("rnd write_idx", 64'(io_ras_write_idx), 64'(e_widx));
        chk("rnd write_addr", 64'(io_ras_write_addr), 64'(e_waddr));
        stk[e_widx] = e_waddr;
      end
      chk("rnd read_idx", 64'(io_ras_read_idx), 64'(e_ridx));
      m_pv_prev  = (rst_i == 0) && (m_cnt != 0);
      m_tgt_prev = stk[m_ptr];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
